// File: rtl/ds_rate_ctrl.sv
// ds_rate_ctrl: run-time rate controller and output scheduler for the down_sample core
// Ports: i_clk/i_rst (sync, active-low); i_valid/o_ready/i_data input stream;
// i_rate_sel/i_rate_load rate request, o_rate/o_pend rate status;
// o_ds_en/o_ds_data core feed, i_ds2/i_ds4/i_ds8 core taps;
// o_data/o_valid/i_ready output FIFO head with downstream backpressure.
module ds_rate_ctrl #(
  parameter int DATA_W     = 16,
  parameter int CORE_LAT   = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_RATE   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_rate_sel,
  input  logic              i_rate_load,
  output logic              o_ds_en,
  output logic [DATA_W-1:0] o_ds_data,
  input  logic [DATA_W-1:0] i_ds2,
  input  logic [DATA_W-1:0] i_ds4,
  input  logic [DATA_W-1:0] i_ds8,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [1:0]        o_rate,
  output logic              o_pend
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [2:0]          ph, mask;
  logic [1:0]          rate, pend_val, ld_val;
  logic                pend, ld_pend, apply, acc, emit, push, pop;
  logic [CORE_LAT-1:0] em;
  logic [1:0]          tap [CORE_LAT];
  logic [DATA_W-1:0]   smp [CORE_LAT];
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [DATA_W-1:0]   wdat;
  logic [AW-1:0]       wp, rp;
  logic [AW:0]         cnt;
  assign acc       = i_valid && o_ready;
  assign o_ds_en   = acc;
  assign o_ds_data = i_data;
  assign mask      = 3'((4'd1 << rate) - 4'd1);
  assign emit      = acc && ((ph & mask) == mask);
  // emits still in the core pipeline are reserved FIFO slots, so a push can never find it full
  assign o_ready   = int'(cnt) + $countones(em) < FIFO_DEPTH;
  assign push      = em[CORE_LAT-1];
  assign o_valid   = cnt != '0;
  assign pop       = o_valid && i_ready;
  assign o_data    = o_valid ? mem[rp] : '0;
  assign o_rate    = rate;
  assign o_pend    = pend;
  assign wdat      = tap[CORE_LAT-1] == 2'd0 ? smp[CORE_LAT-1] :
                     tap[CORE_LAT-1] == 2'd1 ? i_ds2 :
                     tap[CORE_LAT-1] == 2'd2 ? i_ds4 : i_ds8;
  // a load in the same cycle as a frame boundary is applied immediately
  assign ld_val    = i_rate_load ? i_rate_sel : pend_val;
  assign ld_pend   = i_rate_load || pend;
  assign apply     = ld_pend && ((acc && ph == 3'd7) || (ph == 3'd0 && !acc));
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ph       <= '0;
      rate     <= 2'(RST_RATE);
      pend     <= 1'b0;
      pend_val <= '0;
      em       <= '0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
    end else begin
      ph       <= ph + 3'(acc);
      pend_val <= ld_val;
      pend     <= ld_pend && !apply;
      if (apply) rate <= ld_val;
      em[0] <= emit;
      for (int i = CORE_LAT - 1; i > 0; i--) em[i] <= em[i-1];
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // the tap code travels with each emit so later rate changes never touch it
  always_ff @(posedge i_clk) begin
    tap[0] <= rate;
    smp[0] <= i_data;
    for (int i = CORE_LAT - 1; i > 0; i--) begin
      tap[i] <= tap[i-1];
      smp[i] <= smp[i-1];
    end
    if (push) mem[wp] <= wdat;
  end
endmodule

// File: tb/tb_ds_rate_ctrl.sv
// tb_ds_rate_ctrl: directed scoreboard bench for ds_rate_ctrl with a registered core stub
module tb_ds_rate_ctrl;
  logic        clk = 0, rst = 0, i_valid = 0, i_rate_load = 0, i_ready = 1;
  logic [15:0] i_data = 0, ds2, ds4, ds8, o_ds_data, o_data;
  logic [1:0]  i_rate_sel = 0, o_rate;
  logic        o_ready, o_ds_en, o_valid, o_pend;
  int          nchk = 0, nerr = 0, stalls = 0, a;
  int          q[$];
  always #5 clk = ~clk;
  ds_rate_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_rate_sel(i_rate_sel), .i_rate_load(i_rate_load), .o_ds_en(o_ds_en), .o_ds_data(o_ds_data),
    .i_ds2(ds2), .i_ds4(ds4), .i_ds8(ds8), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_rate(o_rate), .o_pend(o_pend)
  );
  always @(posedge clk)
    if (!rst) {ds2, ds4, ds8} <= '0;
    else if (o_ds_en) begin
      ds2 <= o_ds_data + 16'd1000;
      ds4 <= o_ds_data + 16'd2000;
      ds8 <= o_ds_data + 16'd3000;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (rst && o_valid && i_ready) begin
      if (q.size() == 0) begin
        nchk++;
        nerr++;
        $error("FAIL unexpected_out observed=%0d expected=none", o_data);
      end else chk("out", {16'd0, o_data}, q.pop_front());
    end
  task automatic send(input int d, input bit e, input int x);
    int t = 0;
    i_valid = 1;
    i_data  = 16'(d);
    if (e) q.push_back(x);
    @(negedge clk);
    while (!o_ready && t < 50) begin
      stalls++;
      t++;
      @(negedge clk);
    end
    if (!o_ready) begin
      nchk++;
      nerr++;
      $error("FAIL accept_timeout observed=stalled expected=accept of %0d", d);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [1:0] s);
    i_valid     = 0;
    i_rate_sel  = s;
    i_rate_load = 1;
    @(posedge clk);
    #1;
    i_rate_load = 0;
  endtask
  task automatic drain();
    int t = 0;
    i_valid = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", q.size(), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_rate", o_rate, 0);
    chk("rst_pend", o_pend, 0);
    chk("rst_ready", o_ready, 1);
    rst = 1;
    send(1, 1, 1);
    chk("lat_before", o_valid, 0);
    send(2, 1, 2);
    chk("lat_after", o_valid, 1);
    for (int d = 3; d <= 8; d++) send(d, 1, d);
    chk("div1_stalls", stalls, 0);
    drain();
    load(2);
    chk("div4_rate", o_rate, 2);
    chk("div4_pend", o_pend, 0);
    for (int d = 1; d <= 16; d++) send(d, d % 4 == 0, d + 2000);
    drain();
    load(1);
    chk("div2_rate", o_rate, 1);
    for (int d = 1; d <= 3; d++) send(d, d % 2 == 0, d + 1000);
    load(3);
    chk("chg_pend_set", o_pend, 1);
    chk("chg_rate_hold", o_rate, 1);
    for (int d = 4; d <= 8; d++) send(d, d % 2 == 0, d + 1000);
    chk("chg_pend_clr", o_pend, 0);
    chk("chg_rate_new", o_rate, 3);
    for (int d = 9; d <= 16; d++) send(d, d == 16, 3016);
    drain();
    load(0);
    chk("bp_rate", o_rate, 0);
    i_ready = 0;
    a = 0;
    i_valid = 1;
    i_data = 1;
    repeat (8) begin
      @(negedge clk);
      if (o_ready) begin
        q.push_back(a + 1);
        a++;
      end
      @(posedge clk);
      #1;
      i_data = 16'(a + 1);
    end
    chk("bp_accepts", a, 4);
    chk("bp_ready_low", o_ready, 0);
    i_ready = 1;
    for (int d = 5; d <= 8; d++) send(d, 1, d);
    drain();
    load(3);
    chk("rst_test_rate", o_rate, 3);
    i_ready = 0;
    for (int d = 1; d <= 21; d++) send(d, 0, 0);
    load(1);
    chk("pre_rst_pend", o_pend, 1);
    chk("pre_rst_valid", o_valid, 1);
    rst = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_rate", o_rate, 0);
    chk("mid_rst_pend", o_pend, 0);
    chk("mid_rst_data", o_data, 0);
    rst = 1;
    i_ready = 1;
    load(1);
    chk("post_rst_rate", o_rate, 1);
    for (int d = 1; d <= 8; d++) send(d, d % 2 == 0, d + 1000);
    drain();
    load(2);
    chk("idle_rate", o_rate, 2);
    chk("idle_pend", o_pend, 0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
